// File: rtl/mux_pkg.sv
// Geometry helpers shared by the pipelined mux tree: tree depth, stage count,
// levels folded into each stage and lane slice offsets.
package mux_pkg;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int p = 1; p < n; p = p * 2) begin
            r++;
        end
        return r;
    endfunction

    function automatic int num_stages(input int d, input int lps);
        return (d + lps - 1) / lps;
    endfunction

    // The last stage folds whatever levels remain, which may be fewer than lps.
    function automatic int stage_levels(input int d, input int lps, input int k);
        int rem;
        rem = d - k * lps;
        return (rem < lps) ? rem : lps;
    endfunction

    function automatic int lane_lo(input int lane, input int w);
        return lane * w;
    endfunction

endpackage

// File: rtl/mux_tree_stage.sv
// One pipeline slice of the mux tree: a few radix-2 levels driven by the low
// select bits, followed by a valid/ready register carrying the unused select bits.
module mux_tree_stage
    import mux_pkg::*;
#(
    parameter  int LANES_IN  = 4,
    parameter  int LPS       = 2,
    parameter  int W         = 1,
    localparam int SEL_IN_W  = clog2(LANES_IN),
    localparam int LVL       = (LPS < SEL_IN_W) ? LPS : SEL_IN_W,
    localparam int LANES_OUT = LANES_IN >> LVL,
    localparam int SEL_OUT_W = (SEL_IN_W > LVL) ? SEL_IN_W - LVL : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    up_valid,
    output logic                    up_ready,
    input  logic [LANES_IN*W-1:0]   up_data,
    input  logic [SEL_IN_W-1:0]     up_sel,
    input  logic                    up_err,
    output logic                    dn_valid,
    input  logic                    dn_ready,
    output logic [LANES_OUT*W-1:0]  dn_data,
    output logic [SEL_OUT_W-1:0]    dn_sel,
    output logic                    dn_err
);

    logic                  advance;
    logic [LANES_IN*W-1:0] tree;
    logic [SEL_OUT_W-1:0]  sel_rest;

    // Reduce in place: the winner of pair (2m, 2m+1) lands in lane m, which is
    // never read again at that level, so the low LANES_OUT lanes end up as the result.
    always_comb begin
        tree = up_data;
        for (int j = 0; j < LVL; j++) begin
            for (int m = 0; m < (LANES_IN >> (j + 1)); m++) begin
                tree[lane_lo(m, W) +: W] = up_sel[j] ? tree[lane_lo(2 * m + 1, W) +: W]
                                                     : tree[lane_lo(2 * m, W) +: W];
            end
        end
    end

    if (SEL_IN_W > LVL) begin : g_sel_rest
        assign sel_rest = up_sel[SEL_IN_W-1:LVL];
    end else begin : g_sel_done
        assign sel_rest = '0;
    end

    assign advance  = !dn_valid || dn_ready;
    assign up_ready = advance;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dn_valid <= 1'b0;
            dn_data  <= '0;
            dn_sel   <= '0;
            dn_err   <= 1'b0;
        end else if (advance) begin
            dn_valid <= up_valid;
            if (up_valid) begin
                dn_data <= tree[LANES_OUT*W-1:0];
                dn_sel  <= sel_rest;
                dn_err  <= up_err;
            end
        end
    end

endmodule

// File: rtl/mux_tree_pipe.sv
// Pipelined N_IN:1 mux of W-bit lanes: zero-pads to a power of two, flags
// out-of-range selects and chains one register slice per LPS tree levels.
module mux_tree_pipe
    import mux_pkg::*;
#(
    parameter  int N_IN  = 64,
    parameter  int W     = 1,
    parameter  int LPS   = 2,
    localparam int SEL_W = clog2(N_IN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [SEL_W-1:0]  sel,
    input  logic [N_IN*W-1:0] in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W-1:0]      out,
    output logic              sel_err
);

    localparam int D     = SEL_W;
    localparam int N_PAD = 1 << D;
    localparam int S     = num_stages(D, LPS);

    logic               err_in;
    logic [N_PAD*W-1:0] lanes;

    // A bad select sends an all-zero lane vector down the tree so out reads 0.
    always_comb begin
        err_in = (int'(sel) >= N_IN);
        lanes  = '0;
        if (!err_in) begin
            lanes[N_IN*W-1:0] = in;
        end
    end

    for (genvar k = 0; k < S; k++) begin : g_stage
        localparam int SIW       = D - k * LPS;
        localparam int LANES_IN  = 1 << SIW;
        localparam int LVL       = stage_levels(D, LPS, k);
        localparam int LANES_OUT = LANES_IN >> LVL;
        localparam int SOW       = (SIW > LVL) ? SIW - LVL : 1;

        logic                   up_valid;
        logic                   up_ready;
        logic                   up_err;
        logic [LANES_IN*W-1:0]  up_data;
        logic [SIW-1:0]         up_sel;
        logic                   dn_valid;
        logic                   dn_ready;
        logic                   dn_err;
        logic [LANES_OUT*W-1:0] dn_data;
        logic [SOW-1:0]         dn_sel;

        if (k == 0) begin : g_head
            assign up_valid = in_valid;
            assign up_data  = lanes;
            assign up_sel   = sel;
            assign up_err   = err_in;
            assign in_ready = up_ready;
        end else begin : g_link
            assign up_valid = g_stage[k-1].dn_valid;
            assign up_data  = g_stage[k-1].dn_data;
            assign up_sel   = g_stage[k-1].dn_sel;
            assign up_err   = g_stage[k-1].dn_err;
        end

        // The final slice has consumed every select bit; its leftover is a constant 0.
        if (k == S - 1) begin : g_tail
            logic unused_sel;
            assign unused_sel = ^dn_sel;
            assign dn_ready   = out_ready;
            assign out_valid  = dn_valid;
            assign out        = dn_data;
            assign sel_err    = dn_err;
        end else begin : g_mid
            assign dn_ready = g_stage[k+1].up_ready;
        end

        mux_tree_stage #(
            .LANES_IN (LANES_IN),
            .LPS      (LPS),
            .W        (W)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .up_valid (up_valid),
            .up_ready (up_ready),
            .up_data  (up_data),
            .up_sel   (up_sel),
            .up_err   (up_err),
            .dn_valid (dn_valid),
            .dn_ready (dn_ready),
            .dn_data  (dn_data),
            .dn_sel   (dn_sel),
            .dn_err   (dn_err)
        );
    end

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Directed self-checking bench for mux_tree_pipe: four geometries on one clock,
// a queue-based reference model per instance and hand-computed literal checks.
module tb_mux_tree_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic iv0, ir0, ov0, or0, o0, e0;
    logic [5:0]  s0;
    logic [63:0] in0;
    logic iv1, ir1, ov1, or1, o1, e1;
    logic [5:0]  s1;
    logic [47:0] in1;
    logic iv2, ir2, ov2, or2, e2;
    logic [7:0]  o2;
    logic [3:0]  s2;
    logic [127:0] in2;
    logic iv3, ir3, ov3, or3, o3, e3;
    logic        s3;
    logic [1:0]  in3;

    mux_tree_pipe #(.N_IN(64), .W(1), .LPS(2)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .sel(s0), .in(in0),
        .out_valid(ov0), .out_ready(or0), .out(o0), .sel_err(e0));
    mux_tree_pipe #(.N_IN(48), .W(1), .LPS(2)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .sel(s1), .in(in1),
        .out_valid(ov1), .out_ready(or1), .out(o1), .sel_err(e1));
    mux_tree_pipe #(.N_IN(16), .W(8), .LPS(1)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .sel(s2), .in(in2),
        .out_valid(ov2), .out_ready(or2), .out(o2), .sel_err(e2));
    mux_tree_pipe #(.N_IN(2), .W(1), .LPS(2)) u_dut3 (
        .clk(clk), .rst(rst), .in_valid(iv3), .in_ready(ir3), .sel(s3), .in(in3),
        .out_valid(ov3), .out_ready(or3), .out(o3), .sel_err(e3));

    typedef struct {
        logic [7:0] val;
        logic       err;
        int         t;
    } exp_t;

    int   n_in_of [4] = '{64, 48, 16, 2};
    int   w_of    [4] = '{1, 1, 8, 1};
    int   lat_of  [4] = '{3, 3, 4, 1};
    bit   pat     [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    exp_t sb      [4][$];
    int   popped  [4];
    int   cyc;
    int   n_total;
    int   n_pass;
    bit   strict;

    // Reference: lane sel of the packed vector, or 0 when sel lies outside N_IN.
    function automatic logic [7:0] model_out(input int n, input int w, input logic [127:0] lanes, input int s);
        logic [127:0] sh;
        if (s >= n) return 8'h00;
        sh = lanes >> (s * w);
        return sh[7:0] & 8'((1 << w) - 1);
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic ir_of(input int id);
        case (id)
            0: return ir0;
            1: return ir1;
            2: return ir2;
            default: return ir3;
        endcase
    endfunction

    function automatic logic ov_of(input int id);
        case (id)
            0: return ov0;
            1: return ov1;
            2: return ov2;
            default: return ov3;
        endcase
    endfunction

    function automatic logic [7:0] out_of(input int id);
        case (id)
            0: return {7'b0, o0};
            1: return {7'b0, o1};
            2: return o2;
            default: return {7'b0, o3};
        endcase
    endfunction

    function automatic logic err_of(input int id);
        case (id)
            0: return e0;
            1: return e1;
            2: return e2;
            default: return e3;
        endcase
    endfunction

    task automatic apply_stimulus(input int id, input logic v, input int s, input logic r);
        case (id)
            0: begin iv0 = v; s0 = 6'(s); or0 = r; end
            1: begin iv1 = v; s1 = 6'(s); or1 = r; end
            2: begin iv2 = v; s2 = 4'(s); or2 = r; end
            default: begin iv3 = v; s3 = 1'(s); or3 = r; end
        endcase
    endtask

    task automatic score(input int id, input logic iv, input logic ir, input logic ov, input logic ordy,
                         input logic [7:0] o, input logic se, input logic [127:0] lanes, input int s);
        exp_t e;
        if (ov) begin
            check_output($sformatf("pending_beat%0d", id), 32'(sb[id].size() != 0), 32'd1);
            if (sb[id].size() != 0) begin
                e = sb[id][0];
                check_output($sformatf("out%0d", id), 32'(o), 32'(e.val));
                check_output($sformatf("sel_err%0d", id), 32'(se), 32'(e.err));
                if (ordy) begin
                    if (strict) check_output($sformatf("latency%0d", id), 32'(cyc - e.t), 32'(lat_of[id]));
                    else check_output($sformatf("min_latency%0d", id), 32'((cyc - e.t) >= lat_of[id]), 32'd1);
                    e = sb[id].pop_front();
                    popped[id]++;
                end
            end
        end
        if (iv && ir) begin
            e.val = model_out(n_in_of[id], w_of[id], lanes, s);
            e.err = (s >= n_in_of[id]);
            e.t   = cyc;
            sb[id].push_back(e);
        end
    endtask

    // Single compare process: handshakes seen at the falling edge complete on the next rising edge.
    initial begin
        cyc = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                for (int i = 0; i < 4; i++) sb[i].delete();
            end else begin
                score(0, iv0, ir0, ov0, or0, {7'b0, o0}, e0, {64'b0, in0}, int'(s0));
                score(1, iv1, ir1, ov1, or1, {7'b0, o1}, e1, {80'b0, in1}, int'(s1));
                score(2, iv2, ir2, ov2, or2, o2, e2, in2, int'(s2));
                score(3, iv3, ir3, ov3, or3, {7'b0, o3}, e3, {126'b0, in3}, int'(s3));
            end
            cyc++;
        end
    end

    task automatic send_one(input int id, input int s, input logic [7:0] exp_val, input logic exp_err);
        int n;
        @(posedge clk); #1 apply_stimulus(id, 1'b1, s, 1'b1);
        @(negedge clk);
        check_output($sformatf("in_ready_idle%0d", id), 32'(ir_of(id)), 32'd1);
        @(posedge clk); #1 apply_stimulus(id, 1'b0, s, 1'b1);
        n = 1;
        @(negedge clk);
        while (!ov_of(id) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_output($sformatf("lit_latency%0d_sel%0d", id, s), 32'(n), 32'(lat_of[id]));
        check_output($sformatf("lit_out%0d_sel%0d", id, s), 32'(out_of(id)), 32'(exp_val));
        check_output($sformatf("lit_err%0d_sel%0d", id, s), 32'(err_of(id)), 32'(exp_err));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        int idx;
        n_total = 0;
        n_pass  = 0;
        strict  = 1'b1;
        for (int i = 0; i < 4; i++) popped[i] = 0;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) apply_stimulus(i, 1'b0, 0, 1'b1);
        in0 = 64'hA5A5_A5A5_F0F0_0F0F;
        in1 = 48'h8123_4567_89AB;
        for (int i = 0; i < 16; i++) in2[i*8 +: 8] = 8'(8'h10 + i);
        in3 = 2'b10;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check_output("reset_in_ready", 32'(ir0), 32'd1);
        check_output("reset_out_valid", 32'(ov0), 32'd0);
        check_output("reset_out", 32'(o2), 32'd0);
        check_output("reset_sel_err", 32'(e1), 32'd0);

        check_output("model_pin_sel0", 32'(model_out(64, 1, {64'b0, in0}, 0)), 32'd1);
        check_output("model_pin_sel4", 32'(model_out(64, 1, {64'b0, in0}, 4)), 32'd0);
        check_output("model_pin_sel33", 32'(model_out(64, 1, {64'b0, in0}, 33)), 32'd0);
        check_output("model_pin_sel63", 32'(model_out(64, 1, {64'b0, in0}, 63)), 32'd1);
        check_output("model_pin_wide9", 32'(model_out(16, 8, in2, 9)), 32'h19);
        check_output("model_pin_range", 32'(model_out(48, 1, {80'b0, in1}, 50)), 32'd0);

        // Full-rate sweep over every lane of the default geometry.
        base = popped[0];
        @(posedge clk); #1;
        for (int i = 0; i < 64; i++) begin
            apply_stimulus(0, 1'b1, i, 1'b1);
            @(posedge clk); #1;
        end
        apply_stimulus(0, 1'b0, 0, 1'b1);
        repeat (2) @(negedge clk);
        @(posedge clk);
        check_output("sweep_count_at_65", 32'(popped[0] - base), 32'd63);
        @(negedge clk);
        @(posedge clk); #1;
        check_output("sweep_count_at_66", 32'(popped[0] - base), 32'd64);

        // Backpressure stream with out_ready pattern 1,0,0,1.
        strict = 1'b0;
        base = popped[0];
        idx = 0;
        for (int c = 0; c < 300 && (idx < 20 || sb[0].size() != 0); c++) begin
            apply_stimulus(0, idx < 20, (idx * 7 + 3) % 64, pat[c % 4]);
            @(negedge clk);
            if (idx < 20 && ir0) idx++;
            @(posedge clk); #1;
        end
        apply_stimulus(0, 1'b0, 0, 1'b1);
        check_output("bp_accepted", 32'(idx), 32'd20);
        check_output("bp_delivered", 32'(popped[0] - base), 32'd20);

        // Fill all three stages against a stalled consumer.
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(0, 1'b1, 60 + i, 1'b0);
            @(negedge clk);
            check_output($sformatf("fill_in_ready%0d", i), 32'(ir0), (i < 3) ? 32'd1 : 32'd0);
            @(posedge clk); #1;
        end
        apply_stimulus(0, 1'b0, 0, 1'b1);
        repeat (6) @(posedge clk);
        #1 check_output("fill_drained", 32'(sb[0].size()), 32'd0);

        // Reset while two beats are in flight.
        strict = 1'b0;
        apply_stimulus(0, 1'b1, 0, 1'b0);
        @(posedge clk); #1 apply_stimulus(0, 1'b1, 8, 1'b0);
        @(posedge clk); #1 apply_stimulus(0, 1'b0, 0, 1'b0);
        repeat (2) @(posedge clk);
        #1 check_output("pre_reset_out_valid", 32'(ov0), 32'd1);
        #2 rst = 1'b1;
        #1 check_output("async_reset_out_valid", 32'(ov0), 32'd0);
        check_output("async_reset_out", 32'(o0), 32'd0);
        apply_stimulus(0, 1'b0, 0, 1'b1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_output("post_reset_in_ready", 32'(ir0), 32'd1);
        for (int i = 0; i < 6; i++) begin
            check_output($sformatf("post_reset_quiet%0d", i), 32'(ov0), 32'd0);
            @(negedge clk);
        end

        // Non-power-of-two lane count and range errors.
        strict = 1'b1;
        send_one(1, 47, 8'd1, 1'b0);
        send_one(1, 50, 8'd0, 1'b1);
        send_one(1, 63, 8'd0, 1'b1);
        send_one(1, 0, 8'd1, 1'b0);

        // Wide lanes, one level per stage.
        send_one(2, 9, 8'h19, 1'b0);
        send_one(2, 0, 8'h10, 1'b0);
        send_one(2, 15, 8'h1F, 1'b0);
        base = popped[2];
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) begin
            apply_stimulus(2, 1'b1, 15 - i, 1'b1);
            @(posedge clk); #1;
        end
        apply_stimulus(2, 1'b0, 0, 1'b1);
        repeat (6) @(posedge clk);
        #1 check_output("wide_stream_count", 32'(popped[2] - base), 32'd16);

        // Two-lane degenerate tree.
        send_one(3, 1, 8'd1, 1'b0);
        send_one(3, 0, 8'd0, 1'b0);
        @(posedge clk); #1 in3 = 2'b01;
        send_one(3, 0, 8'd1, 1'b0);
        send_one(3, 1, 8'd0, 1'b0);

        repeat (4) @(posedge clk);
        for (int i = 0; i < 4; i++) check_output($sformatf("queue_empty%0d", i), 32'(sb[i].size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
